// File: rtl/parking_lane_sensor.sv
// Lane front-end: synchronizes and debounces two beam-break inputs and decodes the
// crossing order into fixed-width entry/exit pulses. Optional counters: PARKING_LANE_EVENT_COUNT_EN.
module parking_lane_sensor #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES  = 4000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       beam_a,
    input  logic       beam_b,
    input  logic [1:0] switch_in,
    output logic       entry_sensor,
    output logic       exit_sensor,
    output logic [1:0] event_slot,
    output logic       stuck_fault,
    output logic       lane_busy
`ifdef PARKING_LANE_EVENT_COUNT_EN
    ,
    input  logic       count_clr,
    output logic [7:0] entry_count,
    output logic [7:0] exit_count
`endif
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);
    localparam logic [PW-1:0] PULSE_ONE  = PW'(1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, A1, A2, A3, B1, B2, B3, ABORT} state_t;

    logic [1:0]    rawBeams;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    deb_q;
    logic [DW-1:0] debCnt_q [2];

    state_t        state_q;
    state_t        stateNat;
    state_t        stateNext;
    logic          timeout;
    logic          fireEntry;
    logic          fireExit;
    logic [TW-1:0] dwell_q;
    logic [PW-1:0] pulseCnt_q;
    logic          entry_q;
    logic          exit_q;
    logic [1:0]    slot_q;
    logic          fault_q;
    logic          busy_q;

    // Bit 1 is beam a, bit 0 is beam b, so deb_q is directly the FSM code.
    assign rawBeams = {beam_a, beam_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 2; i++) debCnt_q[i] <= '0;
        end else begin
            sync1_q <= rawBeams;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (debCnt_q[i] == DEB_LAST) begin
                        deb_q[i]    <= sync2_q[i];
                        debCnt_q[i] <= '0;
                    end else begin
                        debCnt_q[i] <= debCnt_q[i] + 1'b1;
                    end
                end else begin
                    debCnt_q[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        stateNat  = state_q;
        fireEntry = 1'b0;
        fireExit  = 1'b0;
        case (state_q)
            IDLE: case (deb_q)
                2'b10:   stateNat = A1;
                2'b01:   stateNat = B1;
                2'b11:   stateNat = ABORT;
                default: ;
            endcase
            A1: case (deb_q)
                2'b11:   stateNat = A2;
                2'b00:   stateNat = IDLE;
                2'b01:   stateNat = ABORT;
                default: ;
            endcase
            A2: case (deb_q)
                2'b01:   stateNat = A3;
                2'b10:   stateNat = A1;
                2'b00:   stateNat = ABORT;
                default: ;
            endcase
            A3: case (deb_q)
                2'b00:   begin stateNat = IDLE; fireEntry = 1'b1; end
                2'b11:   stateNat = A2;
                2'b10:   stateNat = ABORT;
                default: ;
            endcase
            B1: case (deb_q)
                2'b11:   stateNat = B2;
                2'b00:   stateNat = IDLE;
                2'b10:   stateNat = ABORT;
                default: ;
            endcase
            B2: case (deb_q)
                2'b10:   stateNat = B3;
                2'b01:   stateNat = B1;
                2'b00:   stateNat = ABORT;
                default: ;
            endcase
            B3: case (deb_q)
                2'b00:   begin stateNat = IDLE; fireExit = 1'b1; end
                2'b11:   stateNat = B2;
                2'b01:   stateNat = ABORT;
                default: ;
            endcase
            ABORT: if (deb_q == 2'b00) stateNat = IDLE;
            default: stateNat = IDLE;
        endcase
        // Timeout only bites when the lane is stalled, so a legal move on the same edge wins.
        timeout   = (state_q != IDLE) && (stateNat == state_q) && (dwell_q == TO_LAST);
        stateNext = timeout ? ABORT : stateNat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            dwell_q    <= '0;
            entry_q    <= 1'b0;
            exit_q     <= 1'b0;
            pulseCnt_q <= '0;
            slot_q     <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q <= stateNext;
            busy_q  <= (stateNext != IDLE);

            if ((stateNext != state_q) || timeout) begin
                dwell_q <= '0;
            end else if (state_q != IDLE) begin
                dwell_q <= dwell_q + 1'b1;
            end

            // A new event retargets the pulse and restarts its width.
            if (fireEntry || fireExit) begin
                entry_q    <= fireEntry;
                exit_q     <= fireExit;
                pulseCnt_q <= PULSE_LOAD;
                slot_q     <= switch_in;
            end else if (pulseCnt_q == PULSE_ONE) begin
                entry_q    <= 1'b0;
                exit_q     <= 1'b0;
                pulseCnt_q <= '0;
            end else if (pulseCnt_q != '0) begin
                pulseCnt_q <= pulseCnt_q - 1'b1;
            end

            if (timeout) begin
                fault_q <= 1'b1;
            end else if ((state_q == ABORT) && (stateNext == IDLE)) begin
                fault_q <= 1'b0;
            end
        end
    end

    assign entry_sensor = entry_q;
    assign exit_sensor  = exit_q;
    assign event_slot   = slot_q;
    assign stuck_fault  = fault_q;
    assign lane_busy    = busy_q;

`ifdef PARKING_LANE_EVENT_COUNT_EN
    logic [7:0] entryCnt_q;
    logic [7:0] exitCnt_q;

    always_ff @(posedge clk) begin
        if (rst || count_clr) begin
            entryCnt_q <= '0;
            exitCnt_q  <= '0;
        end else begin
            if (fireEntry && (entryCnt_q != 8'hFF)) entryCnt_q <= entryCnt_q + 1'b1;
            if (fireExit && (exitCnt_q != 8'hFF))   exitCnt_q  <= exitCnt_q + 1'b1;
        end
    end

    assign entry_count = entryCnt_q;
    assign exit_count  = exitCnt_q;
`else
    // Counter-free build: events only drive the pulse outputs.
`endif

endmodule

// File: tb/tb_parking_lane_sensor.sv
// Directed bench for parking_lane_sensor with DEBOUNCE=4, PULSE=3, TIMEOUT=200.
// Define PARKING_LANE_EVENT_COUNT_EN to also exercise the event counters.
module tb_parking_lane_sensor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       beam_a = 1'b0;
    logic       beam_b = 1'b0;
    logic [1:0] switch_in = 2'b00;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [1:0] event_slot;
    logic       stuck_fault;
    logic       lane_busy;
`ifdef PARKING_LANE_EVENT_COUNT_EN
    logic       count_clr = 1'b0;
    logic [7:0] entry_count;
    logic [7:0] exit_count;
`endif

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int entryHigh, exitHigh, bothHigh, entryRises, exitRises, busyCnt;
    int entryRiseCyc, busyRiseCyc, faultRiseCyc, faultFallCyc;
    logic prevEntry, prevExit, prevBusy, prevFault;

    parking_lane_sensor #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES(3),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .beam_a(beam_a),
        .beam_b(beam_b),
        .switch_in(switch_in),
        .entry_sensor(entry_sensor),
        .exit_sensor(exit_sensor),
        .event_slot(event_slot),
        .stuck_fault(stuck_fault),
        .lane_busy(lane_busy)
`ifdef PARKING_LANE_EVENT_COUNT_EN
        ,
        .count_clr(count_clr),
        .entry_count(entry_count),
        .exit_count(exit_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic clearTally();
        entryHigh = 0; exitHigh = 0; bothHigh = 0; entryRises = 0; exitRises = 0; busyCnt = 0;
        entryRiseCyc = -1; busyRiseCyc = -1; faultRiseCyc = -1; faultFallCyc = -1;
        prevEntry = entry_sensor; prevExit = exit_sensor;
        prevBusy = lane_busy; prevFault = stuck_fault;
    endtask

    // Holds the raw beams for n clocks, sampling outputs 1 time unit after each edge.
    task automatic applyStimulus(input logic a, input logic b, input int n);
        beam_a = a;
        beam_b = b;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (entry_sensor) entryHigh++;
            if (exit_sensor) exitHigh++;
            if (entry_sensor && exit_sensor) bothHigh++;
            if (entry_sensor && !prevEntry) begin entryRises++; entryRiseCyc = cyc; end
            if (exit_sensor && !prevExit) exitRises++;
            if (lane_busy) busyCnt++;
            if (lane_busy && !prevBusy && busyRiseCyc < 0) busyRiseCyc = cyc;
            if (stuck_fault && !prevFault) faultRiseCyc = cyc;
            if (!stuck_fault && prevFault) faultFallCyc = cyc;
            prevEntry = entry_sensor; prevExit = exit_sensor;
            prevBusy = lane_busy; prevFault = stuck_fault;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3);
        checks++; if (entry_sensor !== 1'b0) begin errors++; $display("[TB] FAIL reset_entry got=%b exp=0", entry_sensor); end
        checks++; if (exit_sensor !== 1'b0) begin errors++; $display("[TB] FAIL reset_exit got=%b exp=0", exit_sensor); end
        checks++; if (event_slot !== 2'b00) begin errors++; $display("[TB] FAIL reset_slot got=%b exp=00", event_slot); end
        checks++; if (stuck_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got=%b exp=0", stuck_fault); end
        checks++; if (lane_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", lane_busy); end
        rst = 1'b0;
    endtask

    task automatic test_entry();
        int c0;
        $display("[TB] entry sequence");
        switch_in = 2'b10;
        clearTally();
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b1, 1'b1, 20);
        applyStimulus(1'b0, 1'b1, 20);
        c0 = cyc;
        applyStimulus(1'b0, 1'b0, 20);
        checks++; if (entryRises !== 1) begin errors++; $display("[TB] FAIL entry_rises got=%0d exp=1", entryRises); end
        checks++; if (entryHigh !== 3) begin errors++; $display("[TB] FAIL entry_width got=%0d exp=3", entryHigh); end
        checks++; if (exitHigh !== 0) begin errors++; $display("[TB] FAIL entry_no_exit got=%0d exp=0", exitHigh); end
        checks++; if (entryRiseCyc - c0 !== 7) begin errors++; $display("[TB] FAIL entry_latency got=%0d exp=7", entryRiseCyc - c0); end
        checks++; if (event_slot !== 2'b10) begin errors++; $display("[TB] FAIL entry_slot got=%b exp=10", event_slot); end
        checks++; if (busyCnt == 0 || lane_busy !== 1'b0) begin errors++; $display("[TB] FAIL entry_busy cycles=%0d final=%b exp=>0,0", busyCnt, lane_busy); end
    endtask

    task automatic test_exit();
        $display("[TB] exit sequence");
        switch_in = 2'b01;
        clearTally();
        applyStimulus(1'b0, 1'b1, 20);
        applyStimulus(1'b1, 1'b1, 20);
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b0, 1'b0, 20);
        checks++; if (exitRises !== 1) begin errors++; $display("[TB] FAIL exit_rises got=%0d exp=1", exitRises); end
        checks++; if (exitHigh !== 3) begin errors++; $display("[TB] FAIL exit_width got=%0d exp=3", exitHigh); end
        checks++; if (entryHigh !== 0) begin errors++; $display("[TB] FAIL exit_no_entry got=%0d exp=0", entryHigh); end
        checks++; if (event_slot !== 2'b01) begin errors++; $display("[TB] FAIL exit_slot got=%b exp=01", event_slot); end
    endtask

    task automatic test_glitch();
        $display("[TB] glitch rejection");
        clearTally();
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 20);
        checks++; if (busyCnt !== 0) begin errors++; $display("[TB] FAIL glitch_busy got=%0d exp=0", busyCnt); end
        checks++; if (entryHigh + exitHigh !== 0) begin errors++; $display("[TB] FAIL glitch_pulse got=%0d exp=0", entryHigh + exitHigh); end
    endtask

    task automatic test_abort();
        $display("[TB] aborted entry and direct jump");
        switch_in = 2'b11;
        clearTally();
        applyStimulus(1'b1, 1'b0, 20);
        checks++; if (lane_busy !== 1'b1) begin errors++; $display("[TB] FAIL backout_busy_high got=%b exp=1", lane_busy); end
        applyStimulus(1'b0, 1'b0, 20);
        checks++; if (lane_busy !== 1'b0) begin errors++; $display("[TB] FAIL backout_busy_low got=%b exp=0", lane_busy); end
        applyStimulus(1'b1, 1'b1, 20);
        checks++; if (lane_busy !== 1'b1) begin errors++; $display("[TB] FAIL jump_busy_high got=%b exp=1", lane_busy); end
        applyStimulus(1'b0, 1'b0, 20);
        checks++; if (lane_busy !== 1'b0) begin errors++; $display("[TB] FAIL jump_busy_low got=%b exp=0", lane_busy); end
        checks++; if (entryHigh + exitHigh !== 0) begin errors++; $display("[TB] FAIL abort_pulse got=%0d exp=0", entryHigh + exitHigh); end
        checks++; if (event_slot !== 2'b01) begin errors++; $display("[TB] FAIL abort_slot got=%b exp=01", event_slot); end
    endtask

    task automatic test_timeout();
        int c0;
        int c1;
        $display("[TB] timeout");
        doReset();
        clearTally();
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 300);
        checks++; if (busyRiseCyc - c0 !== 7) begin errors++; $display("[TB] FAIL to_enter_a1 got=%0d exp=7", busyRiseCyc - c0); end
        checks++; if (faultRiseCyc - busyRiseCyc !== 200) begin errors++; $display("[TB] FAIL to_fault_time got=%0d exp=200", faultRiseCyc - busyRiseCyc); end
        checks++; if (stuck_fault !== 1'b1 || lane_busy !== 1'b1) begin errors++; $display("[TB] FAIL to_held fault=%b busy=%b exp=1,1", stuck_fault, lane_busy); end
        c1 = cyc;
        applyStimulus(1'b0, 1'b0, 20);
        checks++; if (faultFallCyc - c1 !== 7) begin errors++; $display("[TB] FAIL to_clear_time got=%0d exp=7", faultFallCyc - c1); end
        checks++; if (lane_busy !== 1'b0) begin errors++; $display("[TB] FAIL to_idle got=%b exp=0", lane_busy); end
        checks++; if (entryHigh + exitHigh !== 0) begin errors++; $display("[TB] FAIL to_no_event got=%0d exp=0", entryHigh + exitHigh); end
    endtask

    task automatic test_reset_mid_pulse();
        $display("[TB] reset mid-pulse");
        switch_in = 2'b11;
        clearTally();
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b1, 1'b1, 20);
        applyStimulus(1'b0, 1'b1, 20);
        applyStimulus(1'b0, 1'b0, 8);
        checks++; if (entry_sensor !== 1'b1 || event_slot !== 2'b11) begin errors++; $display("[TB] FAIL mid_pulse_active entry=%b slot=%b exp=1,11", entry_sensor, event_slot); end
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1);
        checks++; if (entry_sensor !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_entry got=%b exp=0", entry_sensor); end
        checks++; if (event_slot !== 2'b00) begin errors++; $display("[TB] FAIL mid_reset_slot got=%b exp=00", event_slot); end
        checks++; if (lane_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_busy got=%b exp=0", lane_busy); end
        rst = 1'b0;
        clearTally();
        applyStimulus(1'b0, 1'b0, 6);
        checks++; if (entryHigh !== 0) begin errors++; $display("[TB] FAIL mid_reset_resume got=%0d exp=0", entryHigh); end
    endtask

`ifdef PARKING_LANE_EVENT_COUNT_EN
    task automatic test_counts();
        $display("[TB] event counters");
        doReset();
        clearTally();
        for (int k = 0; k < 256; k++) begin
            applyStimulus(1'b1, 1'b0, 8);
            applyStimulus(1'b1, 1'b1, 8);
            applyStimulus(1'b0, 1'b1, 8);
            applyStimulus(1'b0, 1'b0, 8);
        end
        applyStimulus(1'b0, 1'b0, 5);
        checks++; if (entryRises !== 256) begin errors++; $display("[TB] FAIL cnt_rises got=%0d exp=256", entryRises); end
        checks++; if (entry_count !== 8'd255) begin errors++; $display("[TB] FAIL cnt_saturate got=%0d exp=255", entry_count); end
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b1, 1'b1, 8);
        applyStimulus(1'b0, 1'b1, 8);
        applyStimulus(1'b0, 1'b0, 6);
        count_clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1);
        count_clr = 1'b0;
        checks++; if (entry_sensor !== 1'b1 || entry_count !== 8'd0) begin errors++; $display("[TB] FAIL cnt_clr_prio entry=%b count=%0d exp=1,0", entry_sensor, entry_count); end
        applyStimulus(1'b0, 1'b0, 5);
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b1, 1'b1, 8);
        applyStimulus(1'b0, 1'b1, 8);
        applyStimulus(1'b0, 1'b0, 10);
        checks++; if (entry_count !== 8'd1 || exit_count !== 8'd0) begin errors++; $display("[TB] FAIL cnt_after_clr entry=%0d exit=%0d exp=1,0", entry_count, exit_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_entry();
        test_exit();
        test_glitch();
        test_abort();
        test_timeout();
        test_reset_mid_pulse();
`ifdef PARKING_LANE_EVENT_COUNT_EN
        test_counts();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parking_lane_sensor.md
Name: parking_lane_sensor

Overview:
- Front-end for the parking system; the source side of the entry/exit sensor interface the parking FSM consumes.
- Turns two raw beam-break inputs on a single bidirectional lane into clean, fixed-width entry_sensor / exit_sensor pulses, with a latched slot code.
- Sits between the physical lane sensors and the parking FSM. Runs on the 40 MHz system clock.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized samples required before a debounced beam changes (must be ≥2).
- PULSE_CYCLES, 8, width in clocks of each entry_sensor/exit_sensor pulse (must be ≥1).
- TIMEOUT_CYCLES, 4000000, maximum clocks spent in any non-IDLE state before stuck_fault is raised.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- beam_a  input  1  raw outer beam, 1 = blocked, asynchronous
- beam_b  input  1  raw inner beam, 1 = blocked, asynchronous
- switch_in  input  2  slot-select switches, sampled at event completion
- entry_sensor  output  1  entry pulse, PULSE_CYCLES wide
- exit_sensor  output  1  exit pulse, PULSE_CYCLES wide
- event_slot  output  2  switch_in value latched at the last completed event
- stuck_fault  output  1  lane blocked or sequence stalled past TIMEOUT_CYCLES
- lane_busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0; synchronizers, debounced beams (deb_a, deb_b), all counters and the FSM cleared; state = IDLE.
- Synchronizer: 2-flop synchronizer on each beam.
- Debounce, per beam:
  - The counter increments while the synchronized value ≠ deb; any matching sample clears it.
  - deb updates on the edge where the counter would reach DEBOUNCE_CYCLES.
  - Raw change to deb change = 2 + DEBOUNCE_CYCLES clocks. Glitches shorter than DEBOUNCE_CYCLES samples are fully rejected.
- FSM input: code = {deb_a, deb_b}. Transitions evaluated once per clock.
  - IDLE: 10 → A1; 01 → B1; 11 → ABORT; 00 → stay.
  - A1: 11 → A2; 00 → IDLE (abort, no event); 01 → ABORT.
  - A2: 01 → A3; 10 → A1; 00 → ABORT.
  - A3: 00 → IDLE and fire ENTRY; 11 → A2; 10 → ABORT.
  - B1 / B2 / B3: mirror of A1 / A2 / A3 with a and b swapped. B3 → IDLE on 00 fires EXIT.
  - ABORT: wait for 00, then → IDLE. No event.
- Event firing:
  - On the transition edge, the selected output goes high for exactly PULSE_CYCLES clocks. event_slot ← switch_in on that same edge.
  - Latency: deb reaching 00 to pulse high = 1 clock.
  - If a new event fires while a pulse is active: the pulse counter reloads, the previous output drops, the new output rises on the same edge. entry_sensor and exit_sensor are never high together.
- Timeout:
  - A dwell counter runs in every non-IDLE state and clears on each state change.
  - At TIMEOUT_CYCLES, stuck_fault = 1 and the state is forced to ABORT.
  - stuck_fault clears on the edge ABORT exits to IDLE.
- lane_busy = (state ≠ IDLE), registered with the state.
- Reset mid-sequence or mid-pulse: pulse terminates immediately, no event is produced, event_slot returns to 0.

Optional Feature:
- Macro: PARKING_LANE_EVENT_COUNT_EN.
- When defined:
  - Adds outputs entry_count[7:0] and exit_count[7:0], reset 0.
  - Each increments on the edge its event fires and saturates at 255.
  - Adds input count_clr; a synchronous clear that takes priority over an increment on the same edge.
- When undefined: those ports and registers do not exist. All other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, TIMEOUT_CYCLES=200):
- Entry sequence: raw a,b = 10,11,01,00, each held 20 clocks, switch_in=2'b10. Required: one entry_sensor pulse exactly 3 clocks wide; exit_sensor stays 0; event_slot=2'b10; pulse rises 7 clocks after raw goes 00 (2 sync + 4 debounce + 1).
- Exit sequence: raw 01,10-via-11 (01,11,10,00), each held 20 clocks. Required: one exit_sensor pulse of 3 clocks; entry_sensor stays 0.
- Glitch rejection: 3-clock pulse on beam_a from idle. Required: deb_a never changes; lane_busy stays 0; no pulses.
- Aborted entry: 10 → 00 (car backs out). Required: lane_busy high then low; no pulse. Direct 00 → 11 jump: ABORT entered, then IDLE after 00, no pulse.
- Timeout: hold beam_a blocked 300 clocks. Required: stuck_fault=1 exactly 200 clocks after entering A1; release to 00 clears stuck_fault after debounce + 1 clock; no event.
- Reset mid-pulse: assert rst on the 2nd pulse clock. Required: entry_sensor=0 on the next edge; event_slot=0; state IDLE. With PARKING_LANE_EVENT_COUNT_EN: 256 entries leave entry_count=255; count_clr coincident with an event leaves 0.
